tetris_move_scheduler: RTL and testbench

Turns the raw USB keycode and the per-frame vsync into a stream of one-at-a-time move commands for the Tetris game core: left, right, rotate, soft drop, hard drop, and gravity. It applies delayed-auto-shift (DAS) and auto-repeat (ARR) timing and runs the gravity timer. It arbitrates user moves against gravity over a single valid/ready port into the block-update logic. It sits between `mb_block` (keycode0[7:0]) and the game core, in the 100 MHz `Clk` domain.

---
 rtl/tetris_pkg.sv | 45 ++++
 rtl/frame_tick_gen.sv | 47 ++++
 rtl/tetris_move_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_tetris_move_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared types for the Tetris move scheduler:
//   cmd_t        - move command codes presented to the game core
//   key_state_t  - key FSM states (idle, delayed auto-shift, repeat, hold)
//   KEY_*        - USB HID keycodes that map onto moves
//   key_to_cmd   - keycode -> cmd_t map; unmapped codes yield CMD_NONE
// -----------------------------------------------------------------------------
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_LEFT    = 3'd1,
        CMD_RIGHT   = 3'd2,
        CMD_ROTATE  = 3'd3,
        CMD_SOFT    = 3'd4,
        CMD_HARD    = 3'd5,
        CMD_GRAVITY = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_DAS    = 2'd1,
        KS_REPEAT = 2'd2,
        KS_HOLD   = 2'd3
    } key_state_t;

    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_ROTATE = 8'h1A;
    localparam logic [7:0] KEY_SOFT   = 8'h16;
    localparam logic [7:0] KEY_HARD   = 8'h2C;

    function automatic cmd_t key_to_cmd(input logic [7:0] kc);
        case (kc)
            KEY_LEFT:   return CMD_LEFT;
            KEY_RIGHT:  return CMD_RIGHT;
            KEY_ROTATE: return CMD_ROTATE;
            KEY_SOFT:   return CMD_SOFT;
            KEY_HARD:   return CMD_HARD;
            default:    return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Brings the asynchronous vsync level into the clock domain through two flops
// and detects its rising edge.
// Ports:
//   i_clk        - system clock
//   i_reset      - synchronous active-high reset
//   i_vsync      - raw vsync level (asynchronous)
//   o_tick_pre   - combinational rising-edge pulse; the scheduler evaluates
//                  keys and gravity on this cycle so the registered debug
//                  tick and the posted request land on the same edge
//   o_frame_tick - registered one-cycle pulse per frame
// -----------------------------------------------------------------------------
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_vsync,
    output logic o_tick_pre,
    output logic o_frame_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_tick;
    logic w_rise;

    assign w_rise       = r_sync2 & ~r_prev;
    assign o_tick_pre   = w_rise;
    assign o_frame_tick = r_tick;

    // Synchronizer chain, edge-detect history and registered tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_vsync;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= w_rise;
        end
    end

endmodule

// File: rtl/tetris_move_scheduler.sv
// -----------------------------------------------------------------------------
// tetris_move_scheduler
// Converts the held keycode and per-frame vsync into single move commands
// (DAS/ARR for left/right, per-frame soft drop, one-shot rotate/hard drop)
// plus a gravity timer, arbitrated onto one valid/ready command port.
// Ports:
//   Clk, Reset           - clock, synchronous active-high reset
//   vsync                - VGA vsync level (asynchronous)
//   keycode[7:0]         - HID keycode, 0x00 = no key
//   level[3:0]           - game level (used only with level gravity)
//   game_over            - freezes scheduling and clears pending requests
//   cmd_ready            - game core accepts the presented command
//   cmd_valid, cmd[2:0]  - registered command port (cmd_t codes)
//   frame_tick           - registered one-cycle pulse per frame
// Build option: define TETRIS_SCHED_LEVEL_GRAVITY_EN to shorten the gravity
// period with level; otherwise it is fixed at GRAVITY_INIT.
// -----------------------------------------------------------------------------
module tetris_move_scheduler
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES   = 10,
    parameter int ARR_FRAMES   = 3,
    parameter int GRAVITY_INIT = 48,
    parameter int GRAVITY_MIN  = 4,
    parameter int LEVEL_STEP   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vsync,
    input  logic [7:0] keycode,
    input  logic [3:0] level,
    input  logic       game_over,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       frame_tick
);

    logic       w_tick_pre;
    logic       w_eval;
    cmd_t       w_key;
    key_state_t r_state, w_state_nx;
    cmd_t       r_key, w_key_nx;
    logic [7:0] r_fcnt, w_fcnt_nx, w_fcnt_inc;
    logic       w_post;
    cmd_t       w_post_cmd;
    logic [7:0] r_gcnt, w_gcnt_inc, w_period;
    logic       w_grav_fire;
    logic       r_user_vld;
    cmd_t       r_user_cmd;
    logic       r_grav_pend;
    logic       r_cmd_valid;
    cmd_t       r_cmd;
    logic       w_port_free, w_grant_user, w_grant_grav, w_grant_drop;
    logic       w_grav_outstanding;

    frame_tick_gen u_frame_tick_gen (
        .i_clk        (Clk),
        .i_reset      (Reset),
        .i_vsync      (vsync),
        .o_tick_pre   (w_tick_pre),
        .o_frame_tick (frame_tick)
    );

`ifdef TETRIS_SCHED_LEVEL_GRAVITY_EN
    logic        [8:0] w_level_drop;
    logic signed [8:0] w_grav_diff;
    assign w_level_drop = {5'd0, level} * 9'(LEVEL_STEP);
    assign w_grav_diff  = $signed(9'(GRAVITY_INIT) - w_level_drop);
    assign w_period     = (w_grav_diff < $signed(9'(GRAVITY_MIN))) ? 8'(GRAVITY_MIN)
                                                                  : w_grav_diff[7:0];
`else
    logic w_level_unused;
    assign w_level_unused = ^{level, 8'(GRAVITY_MIN), 8'(LEVEL_STEP)};
    assign w_period       = 8'(GRAVITY_INIT);
`endif

    assign cmd_valid    = r_cmd_valid;
    assign cmd          = r_cmd;
    assign w_eval       = w_tick_pre & ~game_over;
    assign w_key        = key_to_cmd(keycode);
    assign w_fcnt_inc   = r_fcnt + 8'd1;
    assign w_gcnt_inc   = r_gcnt + 8'd1;
    assign w_grav_fire  = (w_gcnt_inc >= w_period);

    // Arbitrate whenever the port is empty or being emptied this cycle.
    assign w_port_free  = ~r_cmd_valid | cmd_ready;
    assign w_grant_user = w_port_free & r_user_vld & ~game_over;
    assign w_grant_grav = w_port_free & ~r_user_vld & r_grav_pend & ~game_over;
    assign w_grant_drop = w_grant_user & ((r_user_cmd == CMD_SOFT) | (r_user_cmd == CMD_HARD));
    // A GRAVITY still waiting on the port absorbs a new gravity expiry.
    assign w_grav_outstanding = r_cmd_valid & ~cmd_ready & (r_cmd == CMD_GRAVITY);

    // Key FSM next state, frame counter and user request for this frame.
    always_comb begin
        w_state_nx = r_state;
        w_key_nx   = r_key;
        w_fcnt_nx  = r_fcnt;
        w_post     = 1'b0;
        w_post_cmd = CMD_NONE;
        if (w_key == CMD_NONE) begin
            w_state_nx = KS_IDLE;
            w_key_nx   = CMD_NONE;
            w_fcnt_nx  = 8'd0;
        end else if ((r_state == KS_IDLE) || (w_key != r_key)) begin
            // Fresh press (or a switch to another mapped key).
            w_post     = 1'b1;
            w_post_cmd = w_key;
            w_key_nx   = w_key;
            case (w_key)
                CMD_LEFT, CMD_RIGHT: begin
                    w_state_nx = KS_DAS;
                    w_fcnt_nx  = 8'd1;
                end
                CMD_SOFT: begin
                    w_state_nx = KS_REPEAT;
                    w_fcnt_nx  = 8'd0;
                end
                default: begin
                    w_state_nx = KS_HOLD;
                    w_fcnt_nx  = 8'd0;
                end
            endcase
        end else begin
            case (r_state)
                KS_DAS: begin
                    if (w_fcnt_inc >= 8'(DAS_FRAMES)) begin
                        w_post     = 1'b1;
                        w_post_cmd = r_key;
                        w_state_nx = KS_REPEAT;
                        w_fcnt_nx  = 8'd0;
                    end else begin
                        w_fcnt_nx  = w_fcnt_inc;
                    end
                end
                KS_REPEAT: begin
                    if (r_key == CMD_SOFT) begin
                        w_post     = 1'b1;
                        w_post_cmd = r_key;
                    end else if (w_fcnt_inc >= 8'(ARR_FRAMES)) begin
                        w_post     = 1'b1;
                        w_post_cmd = r_key;
                        w_fcnt_nx  = 8'd0;
                    end else begin
                        w_fcnt_nx  = w_fcnt_inc;
                    end
                end
                default: begin
                    w_state_nx = r_state;
                end
            endcase
        end
    end

    // Key FSM, gravity timer, pending slots and the registered command port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= KS_IDLE;
            r_key       <= CMD_NONE;
            r_fcnt      <= 8'd0;
            r_gcnt      <= 8'd0;
            r_user_vld  <= 1'b0;
            r_user_cmd  <= CMD_NONE;
            r_grav_pend <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_NONE;
        end else begin
            if (w_eval) begin
                r_state <= w_state_nx;
                r_key   <= w_key_nx;
                r_fcnt  <= w_fcnt_nx;
            end

            // User slot: latest request wins over an ungranted one.
            if (game_over) begin
                r_user_vld <= 1'b0;
            end else if (w_eval && w_post) begin
                r_user_vld <= 1'b1;
                r_user_cmd <= w_post_cmd;
            end else if (w_grant_user) begin
                r_user_vld <= 1'b0;
            end

            // Gravity: drops restart the period; expiries coalesce into one flag.
            if (game_over) begin
                r_grav_pend <= 1'b0;
            end else if (w_grant_drop) begin
                r_grav_pend <= 1'b0;
                r_gcnt      <= 8'd0;
            end else begin
                if (w_eval) begin
                    r_gcnt <= w_grav_fire ? 8'd0 : w_gcnt_inc;
                end
                if (w_eval && w_grav_fire && !w_grav_outstanding) begin
                    r_grav_pend <= 1'b1;
                end else if (w_grant_grav) begin
                    r_grav_pend <= 1'b0;
                end
            end

            // Command port: cmd only changes when a new grant is loaded.
            if (w_grant_user) begin
                r_cmd_valid <= 1'b1;
                r_cmd       <= r_user_cmd;
            end else if (w_grant_grav) begin
                r_cmd_valid <= 1'b1;
                r_cmd       <= CMD_GRAVITY;
            end else if (cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tetris_move_scheduler
// Directed bench for tetris_move_scheduler with hand-computed expectations.
// Inputs are driven 2 time units after the rising clock edge; accepted
// commands are recorded on the falling edge together with the frame number.
// -----------------------------------------------------------------------------
module tb_tetris_move_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       vsync;
    logic [7:0] keycode;
    logic [3:0] level;
    logic       game_over;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_idx = 0;
    int acc_cmd[$];
    int acc_frm[$];
    int bp_bad = 0;
    logic bp_mon = 1'b0;

`ifdef TETRIS_SCHED_LEVEL_GRAVITY_EN
    localparam int LVL_CNT   = 15;
    localparam int LVL_FIRST = 4;
`else
    localparam int LVL_CNT   = 1;
    localparam int LVL_FIRST = 48;
`endif

    always #5 Clk = ~Clk;

    tetris_move_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vsync      (vsync),
        .keycode    (keycode),
        .level      (level),
        .game_over  (game_over),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .frame_tick (frame_tick)
    );

    // Record every handshake and watch command stability under back-pressure.
    always @(negedge Clk) begin
        if (cmd_valid && cmd_ready && !Reset) begin
            acc_cmd.push_back(int'(cmd));
            acc_frm.push_back(frame_idx);
        end
        if (bp_mon && cmd_valid && (cmd != 3'd6)) begin
            bp_bad++;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic frame();
        vsync = 1'b1;
        frame_idx++;
        step(5);
        vsync = 1'b0;
        step(5);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        vsync     = 1'b0;
        keycode   = 8'h00;
        level     = 4'd0;
        game_over = 1'b0;
        cmd_ready = 1'b0;
        step(3);
        Reset = 1'b0;
        acc_cmd.delete();
        acc_frm.delete();
        frame_idx = 0;
        step(1);
    endtask

    function automatic int acc_c(input int i);
        return (i < acc_cmd.size()) ? acc_cmd[i] : -1;
    endfunction

    function automatic int acc_f(input int i);
        return (i < acc_frm.size()) ? acc_frm[i] : -1;
    endfunction

    initial begin
        int exp_r[5] = '{1, 10, 13, 16, 19};

        // Reset state
        do_reset();
        check_val("rst_valid", int'(cmd_valid), 0);
        check_val("rst_cmd", int'(cmd), 0);
        check_val("rst_tick", int'(frame_tick), 0);

        // Tap left: tick 3 cycles after vsync, LEFT presented on the 4th
        cmd_ready = 1'b1;
        keycode   = 8'h04;
        vsync     = 1'b1;
        frame_idx++;
        step(3);
        check_val("tap_tick", int'(frame_tick), 1);
        check_val("tap_valid_early", int'(cmd_valid), 0);
        step(1);
        check_val("tap_valid", int'(cmd_valid), 1);
        check_val("tap_cmd", int'(cmd), 1);
        step(1);
        check_val("tap_valid_drop", int'(cmd_valid), 0);
        vsync = 1'b0;
        step(5);
        keycode = 8'h00;
        frames(5);
        check_val("tap_count", acc_cmd.size(), 1);
        check_val("tap_acc_cmd", acc_c(0), 1);

        // Hold right for 20 frames: DAS 10, ARR 3
        do_reset();
        cmd_ready = 1'b1;
        keycode   = 8'h07;
        frames(20);
        keycode = 8'h00;
        check_val("right_count", acc_cmd.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("right_frame%0d", i), acc_f(i), exp_r[i]);
            check_val($sformatf("right_cmd%0d", i), acc_c(i), 2);
        end

        // Soft drop repeats every frame
        do_reset();
        cmd_ready = 1'b1;
        keycode   = 8'h16;
        frames(3);
        keycode = 8'h00;
        check_val("soft_count", acc_cmd.size(), 3);
        check_val("soft_last_frame", acc_f(2), 3);

        // Back-pressure: gravity held stable, one accept after release
        do_reset();
        bp_mon = 1'b1;
        frames(100);
        bp_mon = 1'b0;
        check_val("bp_valid", int'(cmd_valid), 1);
        check_val("bp_cmd", int'(cmd), 6);
        check_val("bp_stable", bp_bad, 0);
        check_val("bp_no_accept", acc_cmd.size(), 0);
        cmd_ready = 1'b1;
        step(30);
        check_val("bp_accept_count", acc_cmd.size(), 1);
        check_val("bp_accept_cmd", acc_c(0), 6);
        check_val("bp_valid_after", int'(cmd_valid), 0);

        // Hard drop while gravity pending clears it and restarts the period
        do_reset();
        keycode = 8'h04;
        frame();
        keycode = 8'h00;
        frames(47);
        check_val("hd_port_left", int'(cmd), 1);
        keycode = 8'h2C;
        frame();
        keycode   = 8'h00;
        cmd_ready = 1'b1;
        frames(51);
        check_val("hd_count", acc_cmd.size(), 3);
        check_val("hd_cmd0", acc_c(0), 1);
        check_val("hd_cmd1", acc_c(1), 5);
        check_val("hd_cmd2", acc_c(2), 6);
        check_val("hd_grav_frame", acc_f(2), 97);

        // Level 15 gravity
        do_reset();
        level     = 4'd15;
        cmd_ready = 1'b1;
        frames(60);
        check_val("lvl_count", acc_cmd.size(), LVL_CNT);
        check_val("lvl_first", acc_f(0), LVL_FIRST);

        // Reset mid-handshake
        do_reset();
        keycode = 8'h1A;
        frame();
        keycode = 8'h00;
        check_val("rm_valid_before", int'(cmd_valid), 1);
        check_val("rm_cmd_before", int'(cmd), 3);
        Reset = 1'b1;
        step(1);
        check_val("rm_valid", int'(cmd_valid), 0);
        check_val("rm_cmd", int'(cmd), 0);
        check_val("rm_tick", int'(frame_tick), 0);
        Reset = 1'b0;

        // Game over: nothing new scheduled
        do_reset();
        cmd_ready = 1'b1;
        game_over = 1'b1;
        keycode   = 8'h04;
        frames(60);
        check_val("go_no_cmds", acc_cmd.size(), 0);

        // Game over keeps an already-presented command until accepted
        do_reset();
        keycode = 8'h1A;
        frame();
        keycode   = 8'h00;
        game_over = 1'b1;
        frames(2);
        check_val("go_hold_valid", int'(cmd_valid), 1);
        check_val("go_hold_cmd", int'(cmd), 3);
        cmd_ready = 1'b1;
        step(1);
        check_val("go_hold_drop", int'(cmd_valid), 0);
        frames(3);
        check_val("go_hold_count", acc_cmd.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
